// File: rtl/periph_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : periph_bridge
//  Purpose  : Bridges single CPU read/write requests onto a simple strobed
//             peripheral bus. It waits for the matching acknowledge, or aborts
//             with an error flag once the wait budget is used up.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    size_addr : peripheral address width in bits
//    timeout   : maximum number of WAIT cycles before abort (1..255)
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   asynchronous reset, active low
//    cpu_req    in   transfer request (sampled only while idle)
//    cpu_we     in   1 = write, 0 = read
//    cpu_addr   in   transfer address
//    cpu_wdata  in   write data
//    cpu_rdata  out  registered read result (8'hFF on read timeout)
//    cpu_done   out  one-cycle completion pulse
//    cpu_err    out  timeout flag, meaningful only with cpu_done
//    busy       out  transfer in progress
//    read/write out  one-cycle peripheral strobes
//    address    out  peripheral address, stable for the whole transfer
//    data_out   out  write data to the peripheral
//    data_in    in   read data from the peripheral
//    ready_r/w  in   peripheral read / write acknowledges
// ============================================================================
module periph_bridge #(
    parameter int size_addr = 8,
    parameter int timeout   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [size_addr-1:0] cpu_addr,
    input  logic [7:0]           cpu_wdata,
    output logic [7:0]           cpu_rdata,
    output logic                 cpu_done,
    output logic                 cpu_err,
    output logic                 busy,
    output logic                 read,
    output logic                 write,
    output logic [size_addr-1:0] address,
    output logic [7:0]           data_out,
    input  logic [7:0]           data_in,
    input  logic                 ready_r,
    input  logic                 ready_w
);

    // The counter must be able to hold the value of timeout itself.
    localparam int c_cnt_w = (timeout < 2) ? 1 : $clog2(timeout + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(timeout - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic                 r_read;
    logic                 r_write;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [size_addr-1:0] r_addr;
    logic [7:0]           r_dout;
    logic [7:0]           r_rdata;

    // Only the acknowledge matching the latched direction counts; the other
    // one is ignored for the whole transfer.
    logic w_ack;
    logic w_last;

    assign w_ack  = r_we ? ready_w : ready_r;
    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_rdata <= '0;
        end else begin
            // Pulses and strobes last one cycle unless re-asserted below.
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        if (cpu_we) begin
                            r_dout <= cpu_wdata;
                        end
                        r_we    <= cpu_we;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_read  <= ~cpu_we;
                        r_write <= cpu_we;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An acknowledge wins over timeout in the final cycle.
                    if (w_ack) begin
                        r_done  <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= data_in;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= 8'hFF;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign busy      = r_busy;
    assign read      = r_read;
    assign write     = r_write;
    assign address   = r_addr;
    assign data_out  = r_dout;

endmodule
`default_nettype wire
